axi_rd_stride_eng: RTL and testbench

AXI_RD_STRIDE_ENG -- requirements
Module: axi_rd_stride_eng

---
 rtl/axi_pkg.sv | 19 +
 rtl/axi_rd_rbuf.sv | 50 +++++
 rtl/axi_rd_stride_eng.sv | 174 +++++++++++++++++
 tb/tb_axi_rd_stride_eng.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings and stride-engine FSM states
package axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } eng_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_rd_rbuf.sv
// rtl/axi_rd_rbuf.sv - synchronous response FIFO with full/empty flags
module axi_rd_rbuf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_rdata   = r_mem[r_rptr];
    // A pop in the same cycle frees a slot, so a push is legal even when full.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + CW'(1);
            else if (!w_do_push && w_do_pop) r_cnt <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/axi_rd_stride_eng.sv
// rtl/axi_rd_stride_eng.sv - strided AXI read burst issuer with buffered responses
module axi_rd_stride_eng
    import axi_pkg::*;
#(
    parameter int ID_W       = 4,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int MAX_OUTST  = 4,
    parameter int RBUF_DEPTH = 4,
    parameter int NUM_W      = 8,
    parameter int STR_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    input  logic [STR_W-1:0]  cmd_stride,
    input  logic [NUM_W-1:0]  cmd_num,
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic [3:0]        ARREGION,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [ID_W-1:0]   rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_resp,
    output logic              rsp_last,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic              done,
    output logic              err
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int BW = ID_W + DATA_W + 3;

    eng_state_t        r_state;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [STR_W-1:0]  r_stride;
    logic [NUM_W-1:0]  r_num;
    logic [NUM_W-1:0]  r_issued;
    logic [ADDR_W-1:0] r_araddr;
    logic [ID_W-1:0]   r_arid;
    logic [OW-1:0]     r_outst;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic              w_arvalid;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_rlast_hs;
    logic              w_full;
    logic              w_empty;
    logic [BW-1:0]     w_head;

    assign w_accept   = cmd_vld & (r_state == ST_IDLE);
    assign w_arvalid  = (r_state == ST_ISSUE) && (r_outst < OW'(MAX_OUTST));
    assign w_ar_hs    = w_arvalid & ARREADY;
    assign w_r_hs     = RVALID & ~w_full;
    assign w_rlast_hs = w_r_hs & RLAST;

    assign cmd_rdy  = (r_state == ST_IDLE);
    assign ARVALID  = w_arvalid;
    assign ARID     = r_arid;
    assign ARADDR   = r_araddr;
    assign ARLEN    = r_len;
    assign ARSIZE   = r_size;
    assign ARBURST  = r_burst;
    assign ARREGION = 4'd0;
    assign RREADY   = ~w_full;
    assign rsp_vld  = ~w_empty;
    assign {rsp_id, rsp_data, rsp_resp, rsp_last} = w_head;
    assign done     = r_done;
    assign err      = r_err;

    // Command sequencing: accept, issue strided bursts, wait for all data to leave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_stride <= '0;
            r_num    <= '0;
            r_issued <= '0;
            r_araddr <= '0;
            r_arid   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_vld) begin
                        r_len    <= cmd_len;
                        r_size   <= cmd_size;
                        r_burst  <= cmd_burst;
                        r_stride <= cmd_stride;
                        r_num    <= cmd_num;
                        r_araddr <= cmd_addr;
                        r_issued <= '0;
                        if (cmd_num == '0) r_done  <= 1'b1;
                        else               r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_ar_hs) begin
                        r_araddr <= r_araddr + ADDR_W'(r_stride);
                        r_arid   <= r_arid + ID_W'(1);
                        r_issued <= r_issued + NUM_W'(1);
                        if (r_issued + NUM_W'(1) == r_num) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_outst == '0 && w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outstanding-burst count; stray RLASTs with nothing outstanding are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outst <= '0;
        end else if (w_ar_hs && !w_rlast_hs) begin
            r_outst <= r_outst + OW'(1);
        end else if (!w_ar_hs && w_rlast_hs && r_outst != '0) begin
            r_outst <= r_outst - OW'(1);
        end
    end

    // Sticky error flag, cleared by a new command and set by any non-OKAY beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_r_hs && RRESP != RESP_OKAY) begin
            r_err <= 1'b1;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end
    end

    axi_rd_rbuf #(
        .WIDTH (BW),
        .DEPTH (RBUF_DEPTH)
    ) u_rbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_r_hs),
        .i_wdata ({RID, RDATA, RRESP, RLAST}),
        .i_pop   (rsp_rdy),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_axi_rd_stride_eng.sv
// tb/tb_axi_rd_stride_eng.sv - randomized self-checking bench for axi_rd_stride_eng
module tb_axi_rd_stride_eng;
    localparam int ID_W = 4, ADDR_W = 10, DATA_W = 64, MAX_OUTST = 4, RBUF_DEPTH = 4, NUM_W = 8, STR_W = 10;
    localparam int BW = ID_W + DATA_W + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, cmd_vld, cmd_rdy, ARVALID, ARREADY, RLAST, RVALID, RREADY, rsp_last, rsp_vld, rsp_rdy, done, err;
    logic [ADDR_W-1:0] cmd_addr, ARADDR;
    logic [7:0] cmd_len, ARLEN;
    logic [2:0] cmd_size, ARSIZE;
    logic [1:0] cmd_burst, ARBURST, RRESP, rsp_resp;
    logic [STR_W-1:0] cmd_stride;
    logic [NUM_W-1:0] cmd_num;
    logic [ID_W-1:0] ARID, RID, rsp_id;
    logic [3:0] ARREGION;
    logic [DATA_W-1:0] RDATA, rsp_data;

    axi_rd_stride_eng #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST),
                        .RBUF_DEPTH(RBUF_DEPTH), .NUM_W(NUM_W), .STR_W(STR_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_stride(cmd_stride),
        .cmd_num(cmd_num), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_last(rsp_last),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .done(done), .err(err));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Reference model state: a command is a list of bursts at base + i*stride, ids counting up.
    int next_id = 0;
    int m_id0, m_num, m_len, m_base, m_stride, m_outst, err_burst = -1;
    bit m_err;
    int ar_addr_q[$], ar_id_q[$], ar_cyc_q[$];
    int pend_idx_q[$], pend_id_q[$];
    int beat_idx;
    bit r_hold;
    logic [BW-1:0] sent_q[$];
    int sent_total, got_total, done_cnt, ar_bad, rsp_bad, arv_viol, stab_viol;
    bit prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [ID_W-1:0] prev_id;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        ar_addr_q.delete(); ar_id_q.delete(); ar_cyc_q.delete();
        pend_idx_q.delete(); pend_id_q.delete(); sent_q.delete();
        beat_idx = 0; r_hold = 0; m_outst = 0; m_err = 0; prev_stall = 0;
        sent_total = 0; got_total = 0; done_cnt = 0; ar_bad = 0; rsp_bad = 0; arv_viol = 0; stab_viol = 0;
        RVALID = 0;
    endtask

    task automatic send_cmd(input int addr, input int stride, input int num, input int len);
        clear_model();
        m_base = addr; m_stride = stride; m_num = num; m_len = len; m_id0 = next_id;
        next_id = (next_id + num) % (1 << ID_W);
        cmd_addr = ADDR_W'(addr); cmd_stride = STR_W'(stride); cmd_num = NUM_W'(num);
        cmd_len = 8'(len); cmd_size = 3'd3; cmd_burst = 2'b01; cmd_vld = 1'b1;
        for (int i = 0; i < 50 && cmd_rdy !== 1'b1; i++) step();
        n_checks++;
        if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL cmd_accept_timeout got=%b exp=1", cmd_rdy); end
        step();
        cmd_vld = 1'b0;
    endtask

    // Drives AR/R/rsp traffic for up to max_cyc cycles, stops on done, and scores every handshake.
    task automatic run(input int max_cyc, input int ar_pct, input int r_pct, input int rsp_pct);
        for (int c = 0; c < max_cyc; c++) begin
            if (done === 1'b1) begin done_cnt++; break; end
            ARREADY = int'($urandom_range(99)) < ar_pct;
            rsp_rdy = int'($urandom_range(99)) < rsp_pct;
            if (!r_hold) RVALID = 1'b0;
            if (!r_hold && pend_idx_q.size() > 0 && int'($urandom_range(99)) < r_pct) begin
                r_hold = 1'b1; RVALID = 1'b1; RID = ID_W'(pend_id_q[0]);
                RDATA = {$urandom(), $urandom()};
                RRESP = (pend_idx_q[0] == err_burst) ? 2'b10 : 2'b00;
                RLAST = (beat_idx == m_len);
            end
            #1;
            if (prev_stall && (ARVALID !== 1'b1 || ARADDR !== prev_addr || ARID !== prev_id)) stab_viol++;
            if (ARVALID !== ((ar_addr_q.size() < m_num) && (m_outst < MAX_OUTST))) arv_viol++;
            if (ARVALID === 1'b1 && ARREADY === 1'b1) begin
                int i;
                i = ar_addr_q.size();
                if (int'(ARADDR) != (m_base + i * m_stride) % (1 << ADDR_W) || int'(ARID) != (m_id0 + i) % (1 << ID_W)
                    || int'(ARLEN) != m_len) ar_bad++;
                ar_addr_q.push_back(int'(ARADDR)); ar_id_q.push_back(int'(ARID)); ar_cyc_q.push_back(cyc);
                pend_idx_q.push_back(i); pend_id_q.push_back((m_id0 + i) % (1 << ID_W));
                m_outst++;
            end
            prev_stall = (ARVALID === 1'b1) && !ARREADY; prev_addr = ARADDR; prev_id = ARID;
            if (RVALID === 1'b1 && RREADY === 1'b1) begin
                sent_q.push_back({RID, RDATA, RRESP, RLAST}); sent_total++;
                if (RRESP != 2'b00) m_err = 1;
                if (RLAST) begin
                    void'(pend_idx_q.pop_front()); void'(pend_id_q.pop_front());
                    beat_idx = 0; if (m_outst > 0) m_outst--;
                end else beat_idx++;
                r_hold = 1'b0;
            end
            if (rsp_vld === 1'b1 && rsp_rdy === 1'b1) begin
                got_total++;
                if (sent_q.size() == 0) rsp_bad++;
                else if ({rsp_id, rsp_data, rsp_resp, rsp_last} !== sent_q.pop_front()) rsp_bad++;
            end
            step();
        end
        ARREADY = 1'b0; rsp_rdy = 1'b0;
        if (!r_hold) RVALID = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_vld = 0; ARREADY = 0; RVALID = 0; RLAST = 0; RID = 0; RDATA = 0; RRESP = 0; rsp_rdy = 0;
        cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0; cmd_stride = 0; cmd_num = 0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        n_checks += 9;
        if (cmd_rdy !== 1'b1)    begin n_errors++; $display("FAIL reset_cmd_rdy got=%b exp=1", cmd_rdy); end
        if (ARVALID !== 1'b0)    begin n_errors++; $display("FAIL reset_arvalid got=%b exp=0", ARVALID); end
        if (ARID !== '0)         begin n_errors++; $display("FAIL reset_arid got=%0d exp=0", ARID); end
        if (ARADDR !== '0)       begin n_errors++; $display("FAIL reset_araddr got=%0h exp=0", ARADDR); end
        if (rsp_vld !== 1'b0)    begin n_errors++; $display("FAIL reset_rsp_vld got=%b exp=0", rsp_vld); end
        if (RREADY !== 1'b1)     begin n_errors++; $display("FAIL reset_rready got=%b exp=1", RREADY); end
        if (done !== 1'b0)       begin n_errors++; $display("FAIL reset_done got=%b exp=0", done); end
        if (err !== 1'b0)        begin n_errors++; $display("FAIL reset_err got=%b exp=0", err); end
        if (ARREGION !== 4'd0)   begin n_errors++; $display("FAIL reset_arregion got=%0d exp=0", ARREGION); end
    endtask

    task automatic test_basic();
        send_cmd('h100, 64, 3, 0);
        n_checks += 4;
        if (ARVALID !== 1'b1) begin n_errors++; $display("FAIL basic_arvalid got=%b exp=1", ARVALID); end
        if (ARSIZE !== 3'd3)  begin n_errors++; $display("FAIL basic_arsize got=%0d exp=3", ARSIZE); end
        if (ARBURST !== 2'b01) begin n_errors++; $display("FAIL basic_arburst got=%0d exp=1", ARBURST); end
        if (ARREGION !== 4'd0) begin n_errors++; $display("FAIL basic_arregion got=%0d exp=0", ARREGION); end
        run(200, 100, 100, 100);
        n_checks += 5;
        if (done_cnt != 1) begin n_errors++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
        if (ar_addr_q.size() != 3) begin n_errors++; $display("FAIL basic_ar_count got=%0d exp=3", ar_addr_q.size()); end
        if (rsp_bad != 0 || got_total != 3) begin n_errors++; $display("FAIL basic_rsp got=%0d/%0d exp=0/3", rsp_bad, got_total); end
        if (arv_viol != 0) begin n_errors++; $display("FAIL basic_arvalid_rule got=%0d exp=0", arv_viol); end
        if (err !== 1'b0) begin n_errors++; $display("FAIL basic_err got=%b exp=0", err); end
        for (int i = 0; i < 3 && i < ar_addr_q.size(); i++) begin
            n_checks++;
            if (ar_addr_q[i] != 'h100 + 64 * i || ar_id_q[i] != i || ar_cyc_q[i] != ar_cyc_q[0] + i) begin
                n_errors++; $display("FAIL basic_ar%0d got=addr %0h id %0d cyc+%0d exp=addr %0h id %0d cyc+%0d",
                                     i, ar_addr_q[i], ar_id_q[i], ar_cyc_q[i] - ar_cyc_q[0], 'h100 + 64 * i, i, i);
            end
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_width got=%b exp=0", done); end
    endtask

    task automatic test_outstanding();
        send_cmd('h000, 16, 6, 0);
        run(12, 100, 0, 100);
        n_checks += 3;
        if (ar_addr_q.size() != 4) begin n_errors++; $display("FAIL outst_cap got=%0d exp=4", ar_addr_q.size()); end
        if (ARVALID !== 1'b0) begin n_errors++; $display("FAIL outst_arvalid_low got=%b exp=0", ARVALID); end
        if (done_cnt != 0) begin n_errors++; $display("FAIL outst_early_done got=%0d exp=0", done_cnt); end
        run(1, 100, 100, 100);
        run(6, 100, 0, 100);
        n_checks += 2;
        if (ar_addr_q.size() != 5) begin n_errors++; $display("FAIL outst_fifth got=%0d exp=5", ar_addr_q.size()); end
        if (ARVALID !== 1'b0) begin n_errors++; $display("FAIL outst_relimit got=%b exp=0", ARVALID); end
        run(300, 100, 100, 100);
        n_checks += 3;
        if (done_cnt != 1 || ar_addr_q.size() != 6) begin n_errors++; $display("FAIL outst_finish got=done %0d ar %0d exp=done 1 ar 6", done_cnt, ar_addr_q.size()); end
        if (ar_bad != 0 || rsp_bad != 0) begin n_errors++; $display("FAIL outst_data got=%0d/%0d exp=0/0", ar_bad, rsp_bad); end
        if (arv_viol != 0) begin n_errors++; $display("FAIL outst_arvalid_rule got=%0d exp=0", arv_viol); end
    endtask

    task automatic test_backpressure();
        send_cmd('h200, 8, 1, 5);
        run(10, 100, 100, 0);
        n_checks += 3;
        if (sent_total != 4) begin n_errors++; $display("FAIL bp_pushes got=%0d exp=4", sent_total); end
        if (RREADY !== 1'b0) begin n_errors++; $display("FAIL bp_rready_low got=%b exp=0", RREADY); end
        if (rsp_vld !== 1'b1) begin n_errors++; $display("FAIL bp_rsp_vld got=%b exp=1", rsp_vld); end
        run(1, 0, 100, 100);
        n_checks += 2;
        if (got_total != 1) begin n_errors++; $display("FAIL bp_one_pop got=%0d exp=1", got_total); end
        if (RREADY !== 1'b1) begin n_errors++; $display("FAIL bp_rready_high got=%b exp=1", RREADY); end
        run(300, 100, 100, 100);
        n_checks += 2;
        if (done_cnt != 1 || sent_total != 6 || got_total != 6) begin n_errors++; $display("FAIL bp_counts got=done %0d sent %0d got %0d exp=1 6 6", done_cnt, sent_total, got_total); end
        if (rsp_bad != 0 || sent_q.size() != 0) begin n_errors++; $display("FAIL bp_order got=%0d left %0d exp=0 0", rsp_bad, sent_q.size()); end
    endtask

    task automatic test_wrap();
        send_cmd('h3C0, 128, 2, 0);
        run(200, 100, 100, 100);
        n_checks += 2;
        if (done_cnt != 1 || ar_addr_q.size() != 2) begin n_errors++; $display("FAIL wrap_done got=done %0d ar %0d exp=1 2", done_cnt, ar_addr_q.size()); end
        else if (ar_addr_q[0] != 'h3C0 || ar_addr_q[1] != 'h040) begin n_errors++; $display("FAIL wrap_addr got=%0h,%0h exp=3c0,40", ar_addr_q[0], ar_addr_q[1]); end
        if (ar_bad != 0) begin n_errors++; $display("FAIL wrap_ar got=%0d exp=0", ar_bad); end
    endtask

    task automatic test_err();
        err_burst = 1;
        send_cmd('h000, 32, 3, 1);
        run(400, 70, 70, 70);
        err_burst = -1;
        n_checks += 2;
        if (done_cnt != 1 || rsp_bad != 0) begin n_errors++; $display("FAIL err_run got=done %0d bad %0d exp=1 0", done_cnt, rsp_bad); end
        if (err !== 1'b1) begin n_errors++; $display("FAIL err_set got=%b exp=1", err); end
        step();
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        send_cmd('h000, 0, 0, 0);
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL err_clear got=%b exp=0", err); end
    endtask

    task automatic test_zero();
        ARREADY = 1'b1;
        send_cmd('h155, 4, 0, 0);
        n_checks += 3;
        if (done !== 1'b1) begin n_errors++; $display("FAIL zero_done got=%b exp=1", done); end
        if (ARVALID !== 1'b0) begin n_errors++; $display("FAIL zero_arvalid got=%b exp=0", ARVALID); end
        if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL zero_cmd_rdy got=%b exp=1", cmd_rdy); end
        step();
        n_checks += 2;
        if (done !== 1'b0) begin n_errors++; $display("FAIL zero_done_width got=%b exp=0", done); end
        if (ARVALID !== 1'b0) begin n_errors++; $display("FAIL zero_arvalid2 got=%b exp=0", ARVALID); end
        ARREADY = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            int num;
            num = int'($urandom_range(1, 6));
            err_burst = ($urandom_range(1) == 1) ? int'($urandom_range(0, 7)) : -1;
            send_cmd(int'($urandom_range(1023)), int'($urandom_range(1023)), num, int'($urandom_range(3)));
            run(3000, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), int'($urandom_range(20, 100)));
            n_checks += 4;
            if (done_cnt != 1 || ar_addr_q.size() != num) begin n_errors++; $display("FAIL rand%0d_done got=done %0d ar %0d exp=1 %0d", k, done_cnt, ar_addr_q.size(), num); end
            if (ar_bad != 0 || stab_viol != 0 || arv_viol != 0) begin n_errors++; $display("FAIL rand%0d_ar got=%0d/%0d/%0d exp=0/0/0", k, ar_bad, stab_viol, arv_viol); end
            if (rsp_bad != 0 || sent_q.size() != 0 || got_total != num * (m_len + 1)) begin n_errors++; $display("FAIL rand%0d_rsp got=bad %0d beats %0d exp=0 %0d", k, rsp_bad, got_total, num * (m_len + 1)); end
            if (err !== m_err) begin n_errors++; $display("FAIL rand%0d_err got=%b exp=%b", k, err, m_err); end
        end
        err_burst = -1;
    endtask

    task automatic test_reset_mid();
        send_cmd('h080, 64, 6, 2);
        run(6, 100, 100, 0);
        n_checks++;
        if (rsp_vld !== 1'b1) begin n_errors++; $display("FAIL rmid_prefill got=%b exp=1", rsp_vld); end
        #2 rst_n = 1'b0;
        #1;
        n_checks += 8;
        if (cmd_rdy !== 1'b1) begin n_errors++; $display("FAIL rmid_cmd_rdy got=%b exp=1", cmd_rdy); end
        if (ARVALID !== 1'b0) begin n_errors++; $display("FAIL rmid_arvalid got=%b exp=0", ARVALID); end
        if (ARID !== '0) begin n_errors++; $display("FAIL rmid_arid got=%0d exp=0", ARID); end
        if (ARADDR !== '0) begin n_errors++; $display("FAIL rmid_araddr got=%0h exp=0", ARADDR); end
        if (rsp_vld !== 1'b0) begin n_errors++; $display("FAIL rmid_rsp_vld got=%b exp=0", rsp_vld); end
        if (RREADY !== 1'b1) begin n_errors++; $display("FAIL rmid_rready got=%b exp=1", RREADY); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL rmid_done got=%b exp=0", done); end
        if (err !== 1'b0) begin n_errors++; $display("FAIL rmid_err got=%b exp=0", err); end
        clear_model(); next_id = 0;
        step(); step();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin step(); if (done === 1'b1) done_cnt++; end
        n_checks += 2;
        if (done_cnt != 0) begin n_errors++; $display("FAIL rmid_no_done got=%0d exp=0", done_cnt); end
        if (cmd_rdy !== 1'b1 || rsp_vld !== 1'b0) begin n_errors++; $display("FAIL rmid_idle got=%b%b exp=10", cmd_rdy, rsp_vld); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_outstanding();
        test_backpressure();
        test_wrap();
        test_err();
        test_zero();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
